cycseq: RTL



---
 rtl/cycseq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cycseq.sv
// 8085-class machine-cycle / T-state sequencer: M1 fetch, then up to four read/write/I-O cycles, or HALT.
// Outputs decode combinationally from state; bus ready=0 in T2/TW stretches the cycle with TW states.
module cycseq #(
   parameter int IENBSIZE = 6,
   parameter int INSTSIZE = 17,
   parameter int INFO_CYC = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [INSTSIZE-1:0] chk_i,
   input  logic                ready,
   output logic [IENBSIZE-1:0] ienb,
   output logic                ale,
   output logic                rd_,
   output logic                wr_,
   output logic                io_m,
   output logic [1:0]          stat,
   output logic [2:0]          mcyc,
   output logic [2:0]          tcyc
);

   localparam int RRD = 0;
   localparam int RWR = 1;
   localparam int COD = 2;
   localparam int DAT = 3;
   localparam int PC_ = 4;
   localparam int PD_ = 5;

   typedef enum logic [2:0] {
      T_HALT = 3'd0,
      T1     = 3'd1,
      T2     = 3'd2,
      T3     = 3'd3,
      T4     = 3'd4,
      T5     = 3'd5,
      T6     = 3'd6,
      TW     = 3'd7
   } tstate_t;

   tstate_t             r_t;
   logic [2:0]          r_m;
   logic [INFO_CYC-1:0] r_cycgo;
   logic [INFO_CYC-1:0] r_cycrw;
   logic [INFO_CYC-1:0] r_cyccd;
   logic                r_go6;
   logic                r_hlt;
   logic                r_dio;

   logic                w_chk_go6;
   logic                w_chk_hlt;
   logic                w_chk_dio;
   logic [INFO_CYC-1:0] w_chk_cyc;
   logic [INFO_CYC-1:0] w_chk_rw;
   logic [INFO_CYC-1:0] w_chk_cd;
   logic                w_unused;

   assign w_chk_go6 = chk_i[0];
   assign w_chk_hlt = chk_i[2];
   assign w_chk_dio = chk_i[3];
   assign w_chk_cyc = chk_i[7:4];
   assign w_chk_rw  = chk_i[11:8];
   assign w_chk_cd  = chk_i[15:12];
   assign w_unused  = &{1'b0, chk_i[1], chk_i[INSTSIZE-1], r_go6};

   logic       w_m1;
   logic       w_mk;
   logic [1:0] w_idx;
   logic [1:0] w_nidx;
   logic       w_rw;
   logic       w_cd;
   logic       w_more;
   logic       w_bus;
   logic       w_t4;
   logic       w_m1_end;
   logic       w_hlt_e;
   logic       w_cyc0_e;

   assign w_m1   = (r_m == 3'd1);
   assign w_mk   = (r_m >= 3'd2);
   assign w_idx  = r_m[1:0] - 2'd2;
   assign w_nidx = r_m[1:0] - 2'd1;
   assign w_rw   = w_mk && r_cycrw[w_idx];
   assign w_cd   = w_mk && r_cyccd[w_idx];
   assign w_more = (r_m != 3'd5) && r_cycgo[w_nidx];
   assign w_bus  = (r_t == T2) || (r_t == TW) || (r_t == T3);

   // At M1/T4 the instruction info is not latched yet, so decisions use chk_i directly.
   assign w_t4     = w_m1 && (r_t == T4);
   assign w_hlt_e  = w_t4 ? w_chk_hlt    : r_hlt;
   assign w_cyc0_e = w_t4 ? w_chk_cyc[0] : r_cycgo[0];
   assign w_m1_end = w_m1 && ((w_t4 && !w_chk_go6) || (r_t == T6));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_m     <= 3'd1;
         r_t     <= T1;
         r_cycgo <= '0;
         r_cycrw <= '0;
         r_cyccd <= '0;
         r_go6   <= 1'b0;
         r_hlt   <= 1'b0;
         r_dio   <= 1'b0;
      end else begin
         case (r_t)
            T1: r_t <= T2;
            T2, TW: begin
               if (ready) r_t <= T3;
               else       r_t <= TW;
            end
            T3: begin
               if (w_m1) begin
                  r_t <= T4;
               end else if (w_more) begin
                  r_m <= r_m + 3'd1;
                  r_t <= T1;
               end else begin
                  r_m <= 3'd1;
                  r_t <= T1;
               end
            end
            T4: begin
               r_cycgo <= w_chk_cyc;
               r_cycrw <= w_chk_rw;
               r_cyccd <= w_chk_cd;
               r_go6   <= w_chk_go6;
               r_hlt   <= w_chk_hlt;
               r_dio   <= w_chk_dio;
               r_t     <= T5;
            end
            T5:     r_t <= T6;
            T6:     r_t <= T6;
            T_HALT: r_t <= T_HALT;
         endcase
         // End of M1 overrides the per-state step above (T4 without GO6, or T6).
         if (w_m1_end) begin
            if (w_hlt_e) begin
               r_m <= 3'd0;
               r_t <= T_HALT;
            end else if (w_cyc0_e) begin
               r_m <= 3'd2;
               r_t <= T1;
            end else begin
               r_m <= 3'd1;
               r_t <= T1;
            end
         end
      end
   end

   always_comb begin
      ienb      = '0;
      ienb[RRD] = (w_m1 && ((r_t == T4) || (r_t == T5) || (r_t == T6))) ||
                  (w_mk && w_rw && w_bus);
      ienb[RWR] = (w_mk && (r_t == T3) && !w_more) ||
                  (w_m1_end && !w_hlt_e && !w_cyc0_e);
      ienb[COD] = w_m1 && (r_t == T3);
      ienb[DAT] = w_mk && !w_rw && (r_t == T3);
      ienb[PC_] = (w_m1 && (r_t == T3)) || (w_mk && !w_rw && !w_cd && (r_t == T3));
      ienb[PD_] = w_cd;
   end

   assign ale  = (r_t == T1);
   assign rd_  = !((w_m1 || (w_mk && !w_rw)) && w_bus);
   assign wr_  = !(w_mk && w_rw && w_bus);
   assign io_m = r_dio && (r_m == 3'd3);
   assign stat = w_m1 ? 2'b11 : (w_mk ? (w_rw ? 2'b01 : 2'b10) : 2'b00);
   assign mcyc = r_m;
   assign tcyc = r_t;

endmodule
